ooo_flush_sequencer: RTL
========================

Name: ooo_flush_sequencer

Overview:
Control FSM that sequences pipeline-wide recovery for the out-of-order core: traps, interrupts, xRET, FENCE.I and branch mispredicts. It sits beside the hazard unit. It takes trap/redirect requests from commit, waits for in-flight memory and multi-cycle units to drain, issues ordered flushes, then redirects fetch through the privileged PC path. Decode is held off while a sequence is in progress.

Parameters:
WORD_W, 32, width of PC/address values
DRAIN_MAX, 16, cycles in DRAIN before drain_timeout asserts (range 2..255)

Ports:
CLK  in  1  core clock
RST  in  1  synchronous active-high reset
intr_req  in  1  pending interrupt accepted at commit head
exc_req  in  1  commit-head exception (fault/mal/illegal/ecall/ebreak)
ret_req  in  1  commit-head xRET
ifence_req  in  1  commit-head FENCE.I
mispredict  in  1  execute branch/jump mispredict (1-cycle pulse)
trap_vec  in  WORD_W  trap target from priv unit
epc_in  in  WORD_W  return target for xRET
ifence_pc  in  WORD_W  PC after FENCE.I
d_mem_busy  in  1  data memory transaction outstanding
busy_mu  in  1  multiplier occupied
busy_du  in  1  divider occupied
dflushed  in  1  dcache flush complete (pulse or level)
iflushed  in  1  icache flush complete (pulse or level)
pc_en  out  1  fetch PC update enable
if_id_flush  out  1  flush fetch/decode latch
id_ex_flush  out  1  flush decode/issue latch
ex_comm_flush  out  1  flush execute units and ROB
ifence_flush  out  1  request dcache writeback then icache invalidate
insert_priv_pc  out  1  select priv_pc as next fetch PC
priv_pc  out  WORD_W  latched redirect target
intr_taken  out  1  interrupt acknowledged to priv unit
stall_de  out  1  hold decode/dispatch
drain_timeout  out  1  drain exceeded DRAIN_MAX (debug flag)
busy  out  1  FSM not IDLE

Behaviour:
- States: IDLE, DRAIN, FLUSH, REDIRECT, IF_DWAIT, IF_IWAIT.
- Reset (RST high at a CLK edge): state=IDLE, priv_pc=0, drain counter=0. All outputs are 0 except pc_en=1.
- Request priority in IDLE: intr_req > exc_req > ret_req > ifence_req > mispredict. Only one request is accepted per cycle; the others are dropped. Commit re-presents them.
- Acceptance of intr/exc/ret in IDLE:
  - priv_pc latches trap_vec (intr, exc) or epc_in (ret) on the accepting edge.
  - intr_taken is 1 in the acceptance cycle only.
  - Next state is DRAIN.
- Acceptance of ifence in IDLE: priv_pc latches ifence_pc; next state is DRAIN.
- mispredict in IDLE with no higher request:
  - if_id_flush=id_ex_flush=1 combinationally in the same cycle. No state change; fetch redirect is handled by brj_addr.
  - mispredict is ignored in any non-IDLE state.
- DRAIN:
  - stall_de=1, pc_en=0.
  - Counter increments each cycle and saturates at DRAIN_MAX; drain_timeout=1 while counter==DRAIN_MAX.
  - Exit to FLUSH in the first cycle where d_mem_busy=0, busy_mu=0 and busy_du=0. The counter clears on exit.
  - If the condition already holds on entry, DRAIN lasts exactly 1 cycle.
- FLUSH (exactly 1 cycle):
  - if_id_flush=id_ex_flush=ex_comm_flush=1; stall_de=1; pc_en=0.
  - Next state is IF_DWAIT if the accepted request was ifence, otherwise REDIRECT.
- IF_DWAIT:
  - ifence_flush=1, stall_de=1, pc_en=0.
  - Move to IF_IWAIT on dflushed=1.
- IF_IWAIT:
  - ifence_flush=1, stall_de=1, pc_en=0.
  - Move to REDIRECT on iflushed=1.
  - A dflushed/iflushed value already high on state entry counts in that cycle.
- REDIRECT (exactly 1 cycle):
  - insert_priv_pc=1, pc_en=1, if_id_flush=1, stall_de=1.
  - Next state is IDLE.
- Latency, minimum for trap with nothing busy: accept cycle → DRAIN(1) → FLUSH(1) → REDIRECT(1), so insert_priv_pc is asserted 3 cycles after acceptance.
- Requests arriving while busy=1 are ignored.
- RST asserted mid-sequence returns to IDLE next edge with reset outputs; no partial flush completes.
- busy=1 in every state except IDLE.
- stall_de=0 in IDLE.

Decomposition:
- Shared package (rv32i_types_pkg):
  - flush_state_t enum (6 states).
  - flush_cause_t enum {CAUSE_INTR, CAUSE_EXC, CAUSE_RET, CAUSE_IFENCE}, latched alongside priv_pc to choose the post-FLUSH path.
- One natural sub-module: flush_drain_counter, a saturating counter with clear, enable and at_max flag, parameterised by DRAIN_MAX.
- The FSM and output decode live in the top module.

Test Plan:
- exc_req=1 for 1 cycle, trap_vec=0x0000_0100, all busy=0 → FLUSH in cycle+2, insert_priv_pc=1 and priv_pc=0x100 in cycle+3, then IDLE with pc_en=1.
- intr_req and exc_req together, trap_vec=0x200 → intr_taken=1 for 1 cycle only; priv_pc=0x200; exc ignored.
- ret_req, epc_in=0x8000_0040, d_mem_busy=1 for 5 cycles → 5 DRAIN cycles with stall_de=1 and pc_en=0, then FLUSH and REDIRECT to 0x8000_0040.
- ifence_req, ifence_pc=0x1004:
  - dflushed after 4 cycles, iflushed 3 cycles later.
  - Required: ifence_flush held through both waits; REDIRECT to 0x1004; total 1+1+1+4+3+1 cycles.
- busy_du stuck for 20 cycles, DRAIN_MAX=16 → drain_timeout=1 from the 16th DRAIN cycle, FSM still in DRAIN; exits when busy_du drops.
- mispredict in IDLE → if_id_flush=id_ex_flush=1 same cycle, busy stays 0. mispredict during DRAIN is ignored. RST during IF_DWAIT → next cycle IDLE, ifence_flush=0, priv_pc=0.

Source files
------------

// File: rtl/ooo_flush_sequencer_pkg.sv
// Shared types for the pipeline flush sequencer.
//   flush_state_t : sequencer FSM states
//   flush_cause_t : accepted request kind, chooses the post-FLUSH path
//   flush_ctrl_t  : per-state control outputs, decoded by decode_ctrl()
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH,
        ST_REDIRECT,
        ST_IF_DWAIT,
        ST_IF_IWAIT
    } flush_state_t;

    typedef enum logic [1:0] {
        CAUSE_INTR,
        CAUSE_EXC,
        CAUSE_RET,
        CAUSE_IFENCE
    } flush_cause_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_comm_flush;
        logic ifence_flush;
        logic insert_priv_pc;
        logic stall_de;
        logic busy;
    } flush_ctrl_t;

    function automatic flush_ctrl_t decode_ctrl(flush_state_t s);
        flush_ctrl_t c;
        c = '0;
        unique case (s)
            ST_IDLE: begin
                c.pc_en = 1'b1;
            end
            ST_DRAIN: begin
                c.stall_de = 1'b1;
                c.busy     = 1'b1;
            end
            ST_FLUSH: begin
                c.if_id_flush   = 1'b1;
                c.id_ex_flush   = 1'b1;
                c.ex_comm_flush = 1'b1;
                c.stall_de      = 1'b1;
                c.busy          = 1'b1;
            end
            ST_IF_DWAIT, ST_IF_IWAIT: begin
                c.ifence_flush = 1'b1;
                c.stall_de     = 1'b1;
                c.busy         = 1'b1;
            end
            ST_REDIRECT: begin
                c.insert_priv_pc = 1'b1;
                c.pc_en          = 1'b1;
                c.if_id_flush    = 1'b1;
                c.stall_de       = 1'b1;
                c.busy           = 1'b1;
            end
            default: c.pc_en = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ooo_flush_sequencer_drain_counter.sv
// Saturating drain-cycle counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero (wins over en)
//   en       : increment, saturating at DRAIN_MAX
//   at_max   : count == DRAIN_MAX
module flush_drain_counter #(
    parameter int unsigned DRAIN_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int unsigned CW = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] MAX_V = CW'(DRAIN_MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + CW'(1);
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/ooo_flush_sequencer.sv
// Pipeline recovery sequencer: accepts trap/xRET/FENCE.I/mispredict requests
// from commit, drains memory and multi-cycle units, issues ordered flushes
// and redirects fetch to priv_pc.
//   CLK, RST            : clock, synchronous active-high reset
//   *_req, mispredict   : recovery requests (priority intr>exc>ret>ifence>mispredict)
//   trap_vec/epc_in/ifence_pc : redirect targets latched into priv_pc
//   d_mem_busy/busy_mu/busy_du : drain conditions
//   dflushed/iflushed   : FENCE.I cache maintenance handshakes
//   outputs             : pipeline control, priv_pc, debug/status flags
module ooo_flush_sequencer
    import rv32i_types_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned DRAIN_MAX = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              intr_req,
    input  logic              exc_req,
    input  logic              ret_req,
    input  logic              ifence_req,
    input  logic              mispredict,
    input  logic [WORD_W-1:0] trap_vec,
    input  logic [WORD_W-1:0] epc_in,
    input  logic [WORD_W-1:0] ifence_pc,
    input  logic              d_mem_busy,
    input  logic              busy_mu,
    input  logic              busy_du,
    input  logic              dflushed,
    input  logic              iflushed,
    output logic              pc_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_comm_flush,
    output logic              ifence_flush,
    output logic              insert_priv_pc,
    output logic [WORD_W-1:0] priv_pc,
    output logic              intr_taken,
    output logic              stall_de,
    output logic              drain_timeout,
    output logic              busy
);

    flush_state_t      state, state_n;
    flush_cause_t      cause, cause_n;
    logic [WORD_W-1:0] pc_q, pc_n;
    flush_ctrl_t       ctrl_q;

    logic any_req;
    logic drained;
    logic cnt_en;
    logic cnt_clr;
    logic at_max;
    logic mp_flush;

    assign any_req = intr_req | exc_req | ret_req | ifence_req;
    assign drained = ~(d_mem_busy | busy_mu | busy_du);

    always_comb begin
        state_n = state;
        cause_n = cause;
        pc_n    = pc_q;
        unique case (state)
            ST_IDLE: begin
                if (intr_req) begin
                    cause_n = CAUSE_INTR;
                    pc_n    = trap_vec;
                    state_n = ST_DRAIN;
                end else if (exc_req) begin
                    cause_n = CAUSE_EXC;
                    pc_n    = trap_vec;
                    state_n = ST_DRAIN;
                end else if (ret_req) begin
                    cause_n = CAUSE_RET;
                    pc_n    = epc_in;
                    state_n = ST_DRAIN;
                end else if (ifence_req) begin
                    cause_n = CAUSE_IFENCE;
                    pc_n    = ifence_pc;
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN:    if (drained)  state_n = ST_FLUSH;
            ST_FLUSH:    state_n = (cause == CAUSE_IFENCE) ? ST_IF_DWAIT : ST_REDIRECT;
            ST_IF_DWAIT: if (dflushed) state_n = ST_IF_IWAIT;
            ST_IF_IWAIT: if (iflushed) state_n = ST_REDIRECT;
            ST_REDIRECT: state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    // Counting starts on the accepting edge so the count equals the
    // number of the current DRAIN cycle; timeout then lands on cycle DRAIN_MAX.
    assign cnt_en  = ((state == ST_IDLE) && any_req) || (state == ST_DRAIN);
    assign cnt_clr = (state == ST_DRAIN) && drained;

    flush_drain_counter #(
        .DRAIN_MAX(DRAIN_MAX)
    ) u_drain_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .at_max(at_max)
    );

    // State-derived controls are registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            cause  <= CAUSE_INTR;
            pc_q   <= '0;
            ctrl_q <= decode_ctrl(ST_IDLE);
        end else begin
            state  <= state_n;
            cause  <= cause_n;
            pc_q   <= pc_n;
            ctrl_q <= decode_ctrl(state_n);
        end
    end

    // Same-cycle responses: interrupt ack and mispredict front-end flush.
    assign intr_taken = (state == ST_IDLE) && intr_req;
    assign mp_flush   = (state == ST_IDLE) && mispredict && !any_req;

    assign pc_en          = ctrl_q.pc_en;
    assign if_id_flush    = ctrl_q.if_id_flush | mp_flush;
    assign id_ex_flush    = ctrl_q.id_ex_flush | mp_flush;
    assign ex_comm_flush  = ctrl_q.ex_comm_flush;
    assign ifence_flush   = ctrl_q.ifence_flush;
    assign insert_priv_pc = ctrl_q.insert_priv_pc;
    assign stall_de       = ctrl_q.stall_de;
    assign busy           = ctrl_q.busy;
    assign priv_pc        = pc_q;
    assign drain_timeout  = at_max;

endmodule
